uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 asynchronous serial receiver.
//
// Oversamples the RS-232 RX line with the system clock, detects the falling
// edge of a start bit, then samples every bit in the middle of its bit period
// (start, 8 data bits LSB-first, stop). A completed byte is copied to rx_data
// and announced with a one-cycle po_flag strobe.
//
// Ports:
//   CLK        in   1  system clock, rising-edge active
//   RSTn       in   1  asynchronous active-low reset
//   rs232_rx   in   1  serial line, idle high, asynchronous to CLK
//   rx_data    out  8  last good byte (bit0 = first data bit on the line)
//   po_flag    out  1  one-cycle pulse: new byte valid on rx_data
//   frame_err  out  1  (only with UART_RX_STOP_CHECK_EN) one-cycle pulse when
//                      the stop bit is sampled low; the byte is then dropped
//
// Build option:
//   UART_RX_STOP_CHECK_EN  when defined, the stop bit is checked and the
//                          frame_err port exists. When undefined, the stop bit
//                          value is ignored and every frame is delivered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int BAUD_CNT_MAX  = 56,
    parameter int BAUD_CNT_HALF = BAUD_CNT_MAX / 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag
`ifdef UART_RX_STOP_CHECK_EN
    ,
    output logic       frame_err
`endif
);

    localparam int BW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT_MAX - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_CNT_HALF);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_LAST  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Synchroniser chain; rx_s3 exists only to detect the falling edge.
    logic rx_s1;
    logic rx_s2;
    logic rx_s3;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [BW-1:0] baud_cnt_r;
    logic [BW-1:0] baud_cnt_nxt_s;
    logic [3:0]    bit_cnt_r;
    logic [3:0]    bit_cnt_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic [7:0]    rx_data_r;
    logic [7:0]    rx_data_nxt_s;
    logic          po_flag_r;
    logic          po_flag_nxt_s;
`ifdef UART_RX_STOP_CHECK_EN
    logic          frame_err_r;
    logic          frame_err_nxt_s;
`endif

    logic fall_s;
    logic sample_s;

    // Two-flop synchroniser plus edge-detect flop, reset to the idle level.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rs232_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign fall_s   = (rx_s2 == 1'b0) && (rx_s3 == 1'b1);
    assign sample_s = (state_r == ST_RECV) && (baud_cnt_r == BAUD_HALF);

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r     <= ST_IDLE;
            baud_cnt_r  <= BAUD_ZERO;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            po_flag_r   <= 1'b0;
`ifdef UART_RX_STOP_CHECK_EN
            frame_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            baud_cnt_r  <= baud_cnt_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            po_flag_r   <= po_flag_nxt_s;
`ifdef UART_RX_STOP_CHECK_EN
            frame_err_r <= frame_err_nxt_s;
`endif
        end
    end

    // Next-state logic: bit timing, sampling, shifting and byte delivery.
    always_comb begin
        state_nxt_s     = state_r;
        baud_cnt_nxt_s  = baud_cnt_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        rx_data_nxt_s   = rx_data_r;
        po_flag_nxt_s   = 1'b0;
`ifdef UART_RX_STOP_CHECK_EN
        frame_err_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                // Counters are held at zero so entry into RECV starts clean.
                baud_cnt_nxt_s = BAUD_ZERO;
                bit_cnt_nxt_s  = 4'd0;
                if (fall_s) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (baud_cnt_r == BAUD_LAST) begin
                    baud_cnt_nxt_s = BAUD_ZERO;
                    bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BAUD_ONE;
                    bit_cnt_nxt_s  = bit_cnt_r;
                end

                if (sample_s) begin
                    if (bit_cnt_r == BIT_START) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (rx_s2) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_RECV;
                        end
                    end else if (bit_cnt_r <= BIT_LAST) begin
                        // LSB arrives first, so shift in from the top.
                        shift_nxt_s = {rx_s2, shift_r[7:1]};
                        state_nxt_s = ST_RECV;
                    end else begin
                        // Stop bit: leave at mid-bit so a back-to-back start
                        // edge in the second half of the stop bit is caught.
`ifdef UART_RX_STOP_CHECK_EN
                        if (rx_s2) begin
                            rx_data_nxt_s = shift_r;
                            po_flag_nxt_s = 1'b1;
                        end else begin
                            frame_err_nxt_s = 1'b1;
                        end
`else
                        rx_data_nxt_s = shift_r;
                        po_flag_nxt_s = 1'b1;
`endif
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                baud_cnt_nxt_s = BAUD_ZERO;
                bit_cnt_nxt_s  = 4'd0;
            end
        endcase
    end

    assign rx_data = rx_data_r;
    assign po_flag = po_flag_r;
`ifdef UART_RX_STOP_CHECK_EN
    assign frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (default parameters:
// 100 MHz clock, 560 ns per serial bit). Works with and without
// UART_RX_STOP_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BIT_NS = 560;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       line  = 1'b1;
    logic [7:0] rx_data;
    logic       po_flag;
`ifdef UART_RX_STOP_CHECK_EN
    logic       frame_err;
`endif

    always #5 clk = ~clk;

    uart_rx dut (
        .CLK      (clk),
        .RSTn     (rst_n),
        .rs232_rx (line),
        .rx_data  (rx_data),
        .po_flag  (po_flag)
`ifdef UART_RX_STOP_CHECK_EN
        ,
        .frame_err(frame_err)
`endif
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Output monitor, sampled on the falling edge.
    int         pulse_cnt  = 0;
    int         consec_cnt = 0;
    int         ferr_cnt   = 0;
    logic       prev_flag  = 1'b0;
    logic [7:0] got_q[$];
    time        pt_q[$];
    time        stop_t = 0;

    always @(negedge clk) begin
        if (po_flag === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            got_q.push_back(rx_data);
            pt_q.push_back($time);
            if (prev_flag === 1'b1) consec_cnt = consec_cnt + 1;
        end
        prev_flag = po_flag;
`ifdef UART_RX_STOP_CHECK_EN
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
`endif
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        line = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            #(BIT_NS);
        end
        stop_t = $time;
        line   = stop_val;
        #(BIT_NS);
        line = 1'b1;
    endtask

    task automatic test_reset();
        int base;
        line  = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (rx_data !== 8'h00 || po_flag !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_hold: rx_data=%h po_flag=%b, want 00/0", rx_data, po_flag);
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        base  = pulse_cnt;
        #100;
        cmp_cnt++;
        if (pulse_cnt !== base) begin
            err_cnt++;
            $display("FAIL reset_release_strobe: pulses=%0d, want 0", pulse_cnt - base);
        end
        cmp_cnt++;
        if (rx_data !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_release_data: rx_data=%h, want 00", rx_data);
        end
    endtask

    task automatic test_single();
        int base;
        logic [7:0] v;
        longint lat;
        base = pulse_cnt;
        @(posedge clk);
        #3;
        send_byte(8'h55, 1'b1);
        #200;
        cmp_cnt++;
        if (pulse_cnt - base !== 1) begin
            err_cnt++;
            $display("FAIL single_count: pulses=%0d, want 1", pulse_cnt - base);
        end
        if (got_q.size() > base) v = got_q[base]; else v = 8'hxx;
        cmp_cnt++;
        if (v !== 8'h55) begin
            err_cnt++;
            $display("FAIL single_data: got %h, want 55", v);
        end
        cmp_cnt++;
        if (rx_data !== 8'h55) begin
            err_cnt++;
            $display("FAIL single_hold: rx_data=%h, want 55", rx_data);
        end
        // Nominal 31 clocks +-1, observed half a clock later.
        if (pt_q.size() > base) lat = longint'(pt_q[base]) - longint'(stop_t); else lat = -1;
        cmp_cnt++;
        if (lat < 290 || lat > 345) begin
            err_cnt++;
            $display("FAIL single_latency: %0d ns, want 290..345 ns", lat);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] bytes [5];
        logic [7:0] v;
        longint gap;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5;
        bytes[3] = 8'h5A; bytes[4] = 8'h3C;
        base = pulse_cnt;
        @(posedge clk);
        #7;
        for (int i = 0; i < 5; i++) send_byte(bytes[i], 1'b1);
        #200;
        cmp_cnt++;
        if (pulse_cnt - base !== 5) begin
            err_cnt++;
            $display("FAIL b2b_count: pulses=%0d, want 5", pulse_cnt - base);
        end
        for (int i = 0; i < 5; i++) begin
            if (got_q.size() > base + i) v = got_q[base + i]; else v = 8'hxx;
            cmp_cnt++;
            if (v !== bytes[i]) begin
                err_cnt++;
                $display("FAIL b2b_data%0d: got %h, want %h", i, v, bytes[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            if (pt_q.size() > base + i)
                gap = longint'(pt_q[base + i]) - longint'(pt_q[base + i - 1]);
            else
                gap = -1;
            cmp_cnt++;
            if (gap < 5580 || gap > 5620) begin
                err_cnt++;
                $display("FAIL b2b_spacing%0d: %0d ns, want 5580..5620 ns", i, gap);
            end
        end
    endtask

    task automatic test_glitch();
        int base;
        logic [7:0] v;
        base = pulse_cnt;
        @(posedge clk);
        #4;
        line = 1'b0;
        #100;
        line = 1'b1;
        #1000;
        cmp_cnt++;
        if (pulse_cnt !== base) begin
            err_cnt++;
            $display("FAIL glitch_strobe: pulses=%0d, want 0", pulse_cnt - base);
        end
        send_byte(8'hC3, 1'b1);
        #200;
        cmp_cnt++;
        if (pulse_cnt - base !== 1) begin
            err_cnt++;
            $display("FAIL glitch_next_count: pulses=%0d, want 1", pulse_cnt - base);
        end
        if (got_q.size() > base) v = got_q[base]; else v = 8'hxx;
        cmp_cnt++;
        if (v !== 8'hC3) begin
            err_cnt++;
            $display("FAIL glitch_next_data: got %h, want c3", v);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        logic [7:0] b;
        logic [7:0] v;
        b    = 8'hF0;
        base = pulse_cnt;
        @(posedge clk);
        #2;
        line = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            line = b[i];
            #(BIT_NS);
        end
        line = b[4];
        #280;
        rst_n = 1'b0;
        line  = 1'b1;
        #100;
        @(negedge clk);
        cmp_cnt++;
        if (rx_data !== 8'h00 || po_flag !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_state: rx_data=%h po_flag=%b, want 00/0", rx_data, po_flag);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #6000;
        cmp_cnt++;
        if (pulse_cnt !== base) begin
            err_cnt++;
            $display("FAIL midreset_strobe: pulses=%0d, want 0", pulse_cnt - base);
        end
        cmp_cnt++;
        if (rx_data !== 8'h00) begin
            err_cnt++;
            $display("FAIL midreset_data: rx_data=%h, want 00", rx_data);
        end
        send_byte(8'h81, 1'b1);
        #200;
        if (got_q.size() > base) v = got_q[base]; else v = 8'hxx;
        cmp_cnt++;
        if (pulse_cnt - base !== 1 || v !== 8'h81) begin
            err_cnt++;
            $display("FAIL midreset_next: pulses=%0d data=%h, want 1/81", pulse_cnt - base, v);
        end
    endtask

    task automatic test_stop_low();
        int base;
        int fbase;
        base  = pulse_cnt;
        fbase = ferr_cnt;
        @(posedge clk);
        #6;
        send_byte(8'h3C, 1'b0);
        #200;
`ifdef UART_RX_STOP_CHECK_EN
        cmp_cnt++;
        if (pulse_cnt !== base) begin
            err_cnt++;
            $display("FAIL stoplow_strobe: pulses=%0d, want 0", pulse_cnt - base);
        end
        cmp_cnt++;
        if (ferr_cnt - fbase !== 1) begin
            err_cnt++;
            $display("FAIL stoplow_frame_err: pulses=%0d, want 1", ferr_cnt - fbase);
        end
        cmp_cnt++;
        if (rx_data !== 8'h81) begin
            err_cnt++;
            $display("FAIL stoplow_hold: rx_data=%h, want 81", rx_data);
        end
`else
        cmp_cnt++;
        if (pulse_cnt - base !== 1) begin
            err_cnt++;
            $display("FAIL stoplow_strobe: pulses=%0d, want 1", pulse_cnt - base);
        end
        cmp_cnt++;
        if (rx_data !== 8'h3C) begin
            err_cnt++;
            $display("FAIL stoplow_data: rx_data=%h, want 3c", rx_data);
        end
        cmp_cnt++;
        if (ferr_cnt !== fbase) begin
            err_cnt++;
            $display("FAIL stoplow_frame_err: pulses=%0d, want 0", ferr_cnt - fbase);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();
        test_stop_low();
        cmp_cnt++;
        if (consec_cnt !== 0) begin
            err_cnt++;
            $display("FAIL flag_width: consecutive-high cycles=%0d, want 0", consec_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
